// File: rtl/tristate_arb_pkg.sv
// Shared types and elaboration helpers for the tri-state bus arbiter.
`timescale 1ns/1ps
package tristate_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StTurn
  } arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit params_ok(int unsigned n, int unsigned max_hold,
                                   int unsigned turn_cycles);
    return (n >= 2) && (max_hold >= 1) && (turn_cycles >= 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search starting just after the previous owner.
`timescale 1ns/1ps
module rr_picker
  import tristate_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] winner
);

  logic [W-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = W'((32'(last) + k) % N);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/tri_buffer4.sv
// 4-bit tri-state driver; releases the bus (high-Z) while e is low.
`timescale 1ns/1ps
module tri_buffer4 (
  input  logic [3:0] a,
  input  logic       e,
  output logic [3:0] y
);

  assign y = e ? a : 4'bzzzz;

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus with a dead turnaround
// interval between owners, so at most one buffer enable is ever high.
`timescale 1ns/1ps
module tristate_bus_arbiter
  import tristate_arb_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned MAX_HOLD    = 8,
  parameter int unsigned TURN_CYCLES = 1,
  localparam int unsigned W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] owner,
  output logic         busy,
  output logic         turn
);

  localparam int unsigned HW = idx_w(MAX_HOLD);
  localparam int unsigned TW = idx_w(TURN_CYCLES);
  localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TurnMax = TW'(TURN_CYCLES - 1);

  if (!params_ok(N, MAX_HOLD, TURN_CYCLES)) begin : g_param_check
    $fatal(1, "tristate_bus_arbiter: illegal N, MAX_HOLD or TURN_CYCLES");
  end

  arb_state_e   state_q;
  logic [W-1:0] last_q;
  logic [HW-1:0] hold_q;
  logic [TW-1:0] turn_cnt_q;

  logic         found;
  logic [W-1:0] winner;
  logic         others;
  logic         release_bus;

  rr_picker #(
    .N(N)
  ) u_picker (
    .req    (req),
    .last   (last_q),
    .found  (found),
    .winner (winner)
  );

  // Another source is waiting while the current owner holds the bus.
  assign others      = |(req & ~(N'(1) << owner));
  assign release_bus = !req[owner] || ((hold_q == HoldMax) && others);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt        <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      turn       <= 1'b0;
      hold_q     <= '0;
      turn_cnt_q <= '0;
      last_q     <= W'(N - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            state_q <= StGrant;
            gnt     <= N'(1) << winner;
            owner   <= winner;
            busy    <= 1'b1;
            last_q  <= winner;
            hold_q  <= '0;
          end
        end
        StGrant: begin
          if (release_bus) begin
            state_q    <= StTurn;
            gnt        <= '0;
            busy       <= 1'b0;
            turn       <= 1'b1;
            turn_cnt_q <= '0;
          end else if (hold_q != HoldMax) begin
            hold_q <= hold_q + HW'(1);
          end
        end
        StTurn: begin
          if (turn_cnt_q == TurnMax) begin
            turn <= 1'b0;
            if (found) begin
              state_q <= StGrant;
              gnt     <= N'(1) << winner;
              owner   <= winner;
              busy    <= 1'b1;
              last_q  <= winner;
              hold_q  <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            turn_cnt_q <= turn_cnt_q + TW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          gnt     <= '0;
          busy    <= 1'b0;
          turn    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed scenarios plus random requests against a cycle model.
`timescale 1ns/1ps
module tb_tristate_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req_a, req_b, gnt_a, gnt_b;
  logic [1:0] owner_a, owner_b;
  logic       busy_a, busy_b, turn_a, turn_b;
  wire  [3:0] bus_a;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .owner(owner_a), .busy(busy_a),
    .turn(turn_a)
  );

  tristate_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .owner(owner_b), .busy(busy_b),
    .turn(turn_b)
  );

  for (genvar i = 0; i < N; i++) begin : g_buf
    tri_buffer4 u_buf (.a(4'(i + 1)), .e(gnt_a[i]), .y(bus_a));
  end

  // Reference model: owner (-1 = none), cycles held, dead cycles left, last owner.
  typedef struct packed {
    int owner;
    int held;
    int gap;
    int last;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t mreset();
    mstate_t s;
    s.owner = -1;
    s.held  = 0;
    s.gap   = 0;
    s.last  = N - 1;
    return s;
  endfunction

  function automatic int pick(logic [3:0] r, int last);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic mstate_t mstep(mstate_t s, logic [3:0] r, int tc);
    mstate_t n;
    int w;
    n = s;
    if (s.gap > 0) begin
      n.gap = s.gap - 1;
      if (s.gap == 1) begin
        w = pick(r, s.last);
        if (w >= 0) begin
          n.owner = w;
          n.last  = w;
          n.held  = 0;
        end
      end
    end else if (s.owner < 0) begin
      w = pick(r, s.last);
      if (w >= 0) begin
        n.owner = w;
        n.last  = w;
        n.held  = 0;
      end
    end else if (!r[s.owner[1:0]] || (s.held == MH - 1 && (r & ~(4'b0001 << s.owner)) != 0)) begin
      n.owner = -1;
      n.gap   = tc;
    end else if (s.held < MH - 1) begin
      n.held = s.held + 1;
    end
    return n;
  endfunction

  function automatic logic [5:0] exp_obs(mstate_t s);
    logic [3:0] g;
    g = (s.owner >= 0) ? (4'b0001 << s.owner) : 4'b0000;
    return {g, s.owner >= 0, s.gap > 0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= mstep(ma, req_a, 1);
      mb <= mstep(mb, req_b, 3);
    end
  end

  task automatic do_reset();
    req_a = '0;
    req_b = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_a = 4'hF;
    req_b = 4'hF;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt_a, busy_a, turn_a, owner_a} !== 8'h00) begin
      fails++;
      $display("FAIL reset_a: gnt/busy/turn/owner=%b required 00000000",
               {gnt_a, busy_a, turn_a, owner_a});
    end
    checks++;
    if ({gnt_b, busy_b, turn_b, owner_b} !== 8'h00) begin
      fails++;
      $display("FAIL reset_b: gnt/busy/turn/owner=%b required 00000000",
               {gnt_b, busy_b, turn_b, owner_b});
    end
    @(negedge clk);
    checks++;
    if (gnt_a !== 4'b0000) begin
      fails++;
      $display("FAIL reset_held: gnt=%b required 0000", gnt_a);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_release();
    do_reset();
    req_a = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt_a !== 4'b0001 || owner_a !== 2'd0 || busy_a !== 1'b1) begin
      fails++;
      $display("FAIL first_grant: gnt=%b owner=%0d busy=%b required 0001 0 1",
               gnt_a, owner_a, busy_a);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (gnt_a !== 4'b0001) begin
      fails++;
      $display("FAIL grant_held: gnt=%b required 0001", gnt_a);
    end
    req_a = 4'b0000;
    @(negedge clk);
    checks++;
    if (gnt_a !== 4'b0000 || turn_a !== 1'b1) begin
      fails++;
      $display("FAIL release_turn: gnt=%b turn=%b required 0000 1", gnt_a, turn_a);
    end
    @(negedge clk);
    checks++;
    if ({gnt_a, busy_a, turn_a} !== 6'b000000) begin
      fails++;
      $display("FAIL back_to_idle: gnt/busy/turn=%b required 000000", {gnt_a, busy_a, turn_a});
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    do_reset();
    req_a = 4'hF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      // Each owner holds 8 cycles followed by a single dead cycle.
      exp = ((c % 9) == 8) ? 4'b0000 : (4'b0001 << ((c / 9) % 4));
      checks++;
      if (gnt_a !== exp) begin
        fails++;
        $display("FAIL rotation[%0d]: gnt=%b required %b", c, gnt_a, exp);
      end
      checks++;
      if ($countones(gnt_a) > 1 || (gnt_a != 0 && bus_a !== 4'(pick(exp, -1) + 1))) begin
        fails++;
        $display("FAIL rotation_bus[%0d]: gnt=%b bus=%b", c, gnt_a, bus_a);
      end
    end
    req_a = '0;
  endtask

  task automatic test_sole_hold();
    do_reset();
    req_a = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (gnt_a !== 4'b0100 || turn_a !== 1'b0 || owner_a !== 2'd2) begin
        fails++;
        $display("FAIL sole_hold[%0d]: gnt=%b turn=%b owner=%0d required 0100 0 2",
                 c, gnt_a, turn_a, owner_a);
      end
    end
    req_a = '0;
  endtask

  task automatic test_simul_drop();
    do_reset();
    req_a = 4'b0010;
    @(negedge clk);
    req_a = 4'b1010;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (gnt_a !== 4'b0010) begin
        fails++;
        $display("FAIL simul_hold[%0d]: gnt=%b required 0010", c, gnt_a);
      end
    end
    req_a = 4'b1000;
    @(negedge clk);
    checks++;
    if (gnt_a !== 4'b0000 || turn_a !== 1'b1) begin
      fails++;
      $display("FAIL simul_turn: gnt=%b turn=%b required 0000 1", gnt_a, turn_a);
    end
    @(negedge clk);
    checks++;
    if (gnt_a !== 4'b1000 || turn_a !== 1'b0) begin
      fails++;
      $display("FAIL simul_next: gnt=%b turn=%b required 1000 0", gnt_a, turn_a);
    end
    req_a = '0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_a = 4'b0001;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt_a !== 4'b0000 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: gnt=%b busy=%b required 0000 0", gnt_a, busy_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    req_a = 4'b1010;
    @(negedge clk);
    checks++;
    if (gnt_a !== 4'b0010 || owner_a !== 2'd1) begin
      fails++;
      $display("FAIL post_reset_rr: gnt=%b owner=%0d required 0010 1", gnt_a, owner_a);
    end
    req_a = '0;
  endtask

  task automatic test_turn3();
    logic [3:0] toggles [3];
    do_reset();
    req_b = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt_b !== 4'b0001) begin
      fails++;
      $display("FAIL t3_grant: gnt=%b required 0001", gnt_b);
    end
    toggles[0] = 4'b0100;
    toggles[1] = 4'b0000;
    toggles[2] = 4'b1000;
    req_b = 4'b0000;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checks++;
      if (gnt_b !== 4'b0000 || turn_b !== 1'b1) begin
        fails++;
        $display("FAIL t3_gap[%0d]: gnt=%b turn=%b required 0000 1", t, gnt_b, turn_b);
      end
      req_b = toggles[t];
    end
    @(negedge clk);
    checks++;
    if (gnt_b !== 4'b1000 || turn_b !== 1'b0) begin
      fails++;
      $display("FAIL t3_winner: gnt=%b turn=%b required 1000 0", gnt_b, turn_b);
    end
    // A request seen only early in TURN must not win.
    toggles[0] = 4'b0010;
    toggles[1] = 4'b0000;
    toggles[2] = 4'b0000;
    req_b = 4'b0000;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      req_b = toggles[t];
    end
    @(negedge clk);
    checks++;
    if ({gnt_b, busy_b, turn_b} !== 6'b000000) begin
      fails++;
      $display("FAIL t3_idle: gnt/busy/turn=%b required 000000", {gnt_b, busy_b, turn_b});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt_a, busy_a, turn_a} !== exp_obs(ma)) begin
        fails++;
        $display("FAIL rand_a[%0d]: gnt/busy/turn=%b required %b", c, {gnt_a, busy_a, turn_a},
                 exp_obs(ma));
      end
      checks++;
      if ({gnt_b, busy_b, turn_b} !== exp_obs(mb)) begin
        fails++;
        $display("FAIL rand_b[%0d]: gnt/busy/turn=%b required %b", c, {gnt_b, busy_b, turn_b},
                 exp_obs(mb));
      end
      if (ma.owner >= 0) begin
        checks++;
        if (owner_a !== 2'(ma.owner) || bus_a !== 4'(ma.owner + 1)) begin
          fails++;
          $display("FAIL rand_owner_bus[%0d]: owner=%0d bus=%b required %0d %0d", c, owner_a,
                   bus_a, ma.owner, ma.owner + 1);
        end
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) req_a[i] = ~req_a[i];
        if ($urandom_range(7) == 0) req_b[i] = ~req_b[i];
      end
    end
    req_a = '0;
    req_b = '0;
  endtask

  initial begin
    req_a = '0;
    req_b = '0;
    #1;
    test_reset();
    test_release();
    test_rotation();
    test_sole_hold();
    test_simul_drop();
    test_reset_mid_grant();
    test_turn3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
